// File: rtl/regfile_wb_queue.sv
// regfile_wb_queue: in-order writeback queue in front of the regfile write port.
// Producers push (reg, data) pairs over valid/ready. At most one entry per
// cycle drains to the regfile. Writes to register 0 are accepted and dropped.
// Optional macro WBQ_FORWARD_EN builds the lookup/forwarding port. When it is
// undefined, lookup_hit and lookup_data are tied to 0.
module regfile_wb_queue #(
  parameter int DEPTH  = 4,
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [ADDR_W-1:0]        in_reg,
  input  logic [DATA_W-1:0]        in_data,
  input  logic                     drain_en,
  output logic [ADDR_W-1:0]        write_reg,
  output logic [DATA_W-1:0]        write_data,
  output logic                     regwrite,
  input  logic [ADDR_W-1:0]        lookup_reg,
  output logic                     lookup_hit,
  output logic [DATA_W-1:0]        lookup_data,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [ADDR_W-1:0] mem_reg  [DEPTH];
  logic [DATA_W-1:0] mem_data [DEPTH];
  logic [PTR_W-1:0]  head;
  logic [PTR_W-1:0]  tail;
  logic              push_fire;
  logic              enq;
  logic              pop;

  assign in_ready   = (count < CNT_W'(DEPTH));
  assign push_fire  = in_valid && in_ready;
  assign enq        = push_fire && (in_reg != '0);
  assign regwrite   = (count != '0) && drain_en;
  assign pop        = regwrite;
  assign write_reg  = (count != '0) ? mem_reg[head]  : '0;
  assign write_data = (count != '0) ? mem_data[head] : '0;

  // Entry storage: written at the tail on an accepted non-zero-register push.
  always_ff @(posedge clk) begin
    if (enq) begin
      mem_reg[tail]  <= in_reg;
      mem_data[tail] <= in_data;
    end
  end

  // Pointer and occupancy update. Reset discards every pending entry.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (enq) tail <= tail + PTR_W'(1);
      if (pop) head <= head + PTR_W'(1);
      case ({enq, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

`ifdef WBQ_FORWARD_EN
  // Scan from oldest to newest so a later match overrides an earlier one.
  always_comb begin
    logic [PTR_W-1:0] idx;
    idx         = '0;
    lookup_hit  = 1'b0;
    lookup_data = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      idx = head + PTR_W'(i);
      if ((CNT_W'(i) < count) && (lookup_reg != '0) && (mem_reg[idx] == lookup_reg)) begin
        lookup_hit  = 1'b1;
        lookup_data = mem_data[idx];
      end
    end
  end
`else
  logic unused_lookup;
  assign unused_lookup = ^lookup_reg;
  assign lookup_hit    = 1'b0;
  assign lookup_data   = '0;
`endif

endmodule

// File: tb/tb_regfile_wb_queue.sv
// Testbench for regfile_wb_queue: directed vector table, reset-mid-operation
// sequence, and randomized traffic checked against a queue-based reference.
module tb_regfile_wb_queue;

  localparam int DEPTH  = 4;
  localparam int DATA_W = 32;
  localparam int ADDR_W = 5;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic [ADDR_W-1:0] in_reg = '0;
  logic [DATA_W-1:0] in_data = '0;
  logic              drain_en = 1'b0;
  logic [ADDR_W-1:0] write_reg;
  logic [DATA_W-1:0] write_data;
  logic              regwrite;
  logic [ADDR_W-1:0] lookup_reg = '0;
  logic              lookup_hit;
  logic [DATA_W-1:0] lookup_data;
  logic [$clog2(DEPTH):0] count;

  regfile_wb_queue #(.DEPTH(DEPTH), .DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_reg(in_reg), .in_data(in_data), .drain_en(drain_en),
    .write_reg(write_reg), .write_data(write_data), .regwrite(regwrite),
    .lookup_reg(lookup_reg), .lookup_hit(lookup_hit), .lookup_data(lookup_data),
    .count(count)
  );

  always #5 clk = ~clk;

`ifdef WBQ_FORWARD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  // Simple regfile fed by the DUT write port.
  logic [DATA_W-1:0] rf [32];
  int ncommit = 0;
  initial for (int i = 0; i < 32; i++) rf[i] = '0;
  always @(posedge clk) begin
    if (regwrite) begin
      rf[write_reg] = write_data;
      ncommit++;
    end
  end

  int vectors = 0;
  int errors  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  typedef struct {
    logic              v;
    logic [ADDR_W-1:0] r;
    logic [DATA_W-1:0] d;
    logic              dr;
    logic [ADDR_W-1:0] lr;
    int                c;
    logic              rdy;
    logic              rw;
    logic [ADDR_W-1:0] wr;
    logic [DATA_W-1:0] wd;
    logic              hit;
    logic [DATA_W-1:0] ld;
    int                rfr;
    logic [DATA_W-1:0] rfv;
  } vec_t;

  function automatic vec_t mk(input logic v, input int r, input int d, input logic dr,
                              input int lr, input int c, input logic rdy, input logic rw,
                              input int wr, input int wd, input logic hit, input int ld,
                              input int rfr, input int rfv);
    vec_t x;
    x.v = v; x.r = ADDR_W'(r); x.d = DATA_W'(d); x.dr = dr; x.lr = ADDR_W'(lr);
    x.c = c; x.rdy = rdy; x.rw = rw; x.wr = ADDR_W'(wr); x.wd = DATA_W'(wd);
    x.hit = hit; x.ld = DATA_W'(ld); x.rfr = rfr; x.rfv = DATA_W'(rfv);
    return x;
  endfunction

  // Reference model: an ordered list of pending (reg, data) pairs.
  typedef struct { logic [ADDR_W-1:0] r; logic [DATA_W-1:0] d; } ent_t;
  ent_t mq[$];

  task automatic rstep(input logic v, input logic [ADDR_W-1:0] r, input logic [DATA_W-1:0] d,
                       input logic dr, input logic [ADDR_W-1:0] lr);
    logic acc;
    logic ehit;
    logic [DATA_W-1:0] eld;
    ent_t e;
    @(negedge clk);
    in_valid = v; in_reg = r; in_data = d; drain_en = dr; lookup_reg = lr;
    #1;
    ehit = 1'b0; eld = '0;
    if (FWD && lr != '0) begin
      for (int k = mq.size() - 1; k >= 0; k--) begin
        if (mq[k].r == lr) begin ehit = 1'b1; eld = mq[k].d; break; end
      end
    end
    chk("rnd count",    32'(count),    32'(mq.size()));
    chk("rnd in_ready", 32'(in_ready), 32'(mq.size() < DEPTH));
    chk("rnd regwrite", 32'(regwrite), 32'(mq.size() != 0 && dr));
    chk("rnd write_reg",  32'(write_reg),  mq.size() != 0 ? 32'(mq[0].r) : 32'd0);
    chk("rnd write_data", write_data,      mq.size() != 0 ? mq[0].d : 32'd0);
    chk("rnd lookup_hit",  32'(lookup_hit), 32'(ehit));
    chk("rnd lookup_data", lookup_data,     eld);
    acc = v && (mq.size() < DEPTH);
    if (mq.size() != 0 && dr) void'(mq.pop_front());
    if (acc && r != '0) begin e.r = r; e.d = d; mq.push_back(e); end
  endtask

  vec_t vecs[$];
  int   snap;

  initial begin
    // Single write, register-0 discard.
    vecs.push_back(mk(1,12,35,1, 0, 0,1,0, 0, 0, 0, 0,  0, 0));
    vecs.push_back(mk(0, 0, 0,1, 0, 1,1,1,12,35, 0, 0,  0, 0));
    vecs.push_back(mk(0, 0, 0,1, 0, 0,1,0, 0, 0, 0, 0, 12,35));
    vecs.push_back(mk(1, 0,99,1, 0, 0,1,0, 0, 0, 0, 0,  0, 0));
    vecs.push_back(mk(0, 0, 0,1, 0, 0,1,0, 0, 0, 0, 0,  0, 0));
    // Fill, refuse 5th push, drain in order while the 5th gets in and wraps.
    vecs.push_back(mk(1, 8, 9,0, 0, 0,1,0, 0, 0, 0, 0,  0, 0));
    vecs.push_back(mk(1, 3, 4,0, 0, 1,1,0, 8, 9, 0, 0,  0, 0));
    vecs.push_back(mk(1, 5, 6,0, 0, 2,1,0, 8, 9, 0, 0,  0, 0));
    vecs.push_back(mk(1, 7, 8,0, 0, 3,1,0, 8, 9, 0, 0,  0, 0));
    vecs.push_back(mk(1, 9,10,0, 0, 4,0,0, 8, 9, 0, 0,  0, 0));
    vecs.push_back(mk(1, 9,10,1, 0, 4,0,1, 8, 9, 0, 0,  0, 0));
    vecs.push_back(mk(1, 9,10,1, 0, 3,1,1, 3, 4, 0, 0,  8, 9));
    vecs.push_back(mk(0, 0, 0,1, 0, 3,1,1, 5, 6, 0, 0,  3, 4));
    vecs.push_back(mk(0, 0, 0,1, 0, 2,1,1, 7, 8, 0, 0,  5, 6));
    vecs.push_back(mk(0, 0, 0,1, 0, 1,1,1, 9,10, 0, 0,  7, 8));
    vecs.push_back(mk(0, 0, 0,1, 0, 0,1,0, 0, 0, 0, 0,  9,10));
    // Forwarding, newest wins.
    vecs.push_back(mk(1,12,35,0,12, 0,1,0, 0, 0, 0, 0,  0, 0));
    vecs.push_back(mk(1,12,77,0,12, 1,1,0,12,35, 1,35,  0, 0));
    vecs.push_back(mk(0, 0, 0,0,12, 2,1,0,12,35, 1,77,  0, 0));
    vecs.push_back(mk(0, 0, 0,1,12, 2,1,1,12,35, 1,77,  0, 0));
    vecs.push_back(mk(0, 0, 0,1,12, 1,1,1,12,77, 1,77, 12,35));
    vecs.push_back(mk(0, 0, 0,1,12, 0,1,0, 0, 0, 0, 0, 12,77));
    // Simultaneous push and pop keep count at 2.
    vecs.push_back(mk(1, 1,11,0, 0, 0,1,0, 0, 0, 0, 0,  0, 0));
    vecs.push_back(mk(1, 2,22,0, 0, 1,1,0, 1,11, 0, 0,  0, 0));
    vecs.push_back(mk(1, 3,33,1, 0, 2,1,1, 1,11, 0, 0,  0, 0));
    vecs.push_back(mk(1, 4,44,1, 0, 2,1,1, 2,22, 0, 0,  0, 0));
    vecs.push_back(mk(1, 5,55,1, 0, 2,1,1, 3,33, 0, 0,  0, 0));

    // Reset state.
    lookup_reg = 5'd12;
    #50;
    chk("reset count",       32'(count),      0);
    chk("reset in_ready",    32'(in_ready),   1);
    chk("reset regwrite",    32'(regwrite),   0);
    chk("reset write_reg",   32'(write_reg),  0);
    chk("reset write_data",  write_data,      0);
    chk("reset lookup_hit",  32'(lookup_hit), 0);
    chk("reset lookup_data", lookup_data,     0);
    #50;
    @(negedge clk);
    rst = 1'b0;

    foreach (vecs[i]) begin
      @(negedge clk);
      in_valid = vecs[i].v; in_reg = vecs[i].r; in_data = vecs[i].d;
      drain_en = vecs[i].dr; lookup_reg = vecs[i].lr;
      #1;
      chk($sformatf("row%0d count", i),      32'(count),      32'(vecs[i].c));
      chk($sformatf("row%0d in_ready", i),   32'(in_ready),   32'(vecs[i].rdy));
      chk($sformatf("row%0d regwrite", i),   32'(regwrite),   32'(vecs[i].rw));
      chk($sformatf("row%0d write_reg", i),  32'(write_reg),  32'(vecs[i].wr));
      chk($sformatf("row%0d write_data", i), write_data,      vecs[i].wd);
      chk($sformatf("row%0d lookup_hit", i), 32'(lookup_hit), FWD ? 32'(vecs[i].hit) : 32'd0);
      chk($sformatf("row%0d lookup_data", i), lookup_data,    FWD ? vecs[i].ld : 32'd0);
      if (vecs[i].rfr != 0)
        chk($sformatf("row%0d regfile", i), rf[vecs[i].rfr], vecs[i].rfv);
    end

    // Asynchronous reset with (4,44),(5,55) pending: nothing more may commit.
    @(negedge clk);
    in_valid = 1'b0; drain_en = 1'b1; lookup_reg = '0;
    #1;
    chk("prerst count",     32'(count),     2);
    chk("prerst write_reg", 32'(write_reg), 4);
    snap = ncommit;
    #2 rst = 1'b1;
    #1;
    chk("midrst count",     32'(count),     0);
    chk("midrst regwrite",  32'(regwrite),  0);
    chk("midrst write_reg", 32'(write_reg), 0);
    chk("midrst in_ready",  32'(in_ready),  1);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    chk("postrst commits", 32'(ncommit), 32'(snap));
    chk("postrst rf4",     rf[4],        0);
    chk("postrst count",   32'(count),   0);

    // Randomized traffic against the queue model.
    mq.delete();
    for (int n = 0; n < 500; n++) begin
      rstep($urandom_range(0, 9) < 7,
            ADDR_W'($urandom_range(0, 7)),
            $urandom,
            $urandom_range(0, 9) < ((n / 100) % 2 == 0 ? 6 : 3),
            ADDR_W'($urandom_range(0, 7)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
